// File: rtl/usb_stream_in.sv
// FX2 Slave FIFO writer for EP6 (IN): 2-entry skid buffer feeding the FIFO, with
// short-packet commit via PKTEND on an explicit flush or an idle timeout.
module usb_stream_in #(
  parameter int unsigned PKT_WORDS    = 256,
  parameter int unsigned IDLE_TIMEOUT = 1024,
  parameter int unsigned GAP_CYCLES   = 3
) (
  input  logic        fx2_ifclk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        data_in_valid,
  output logic        data_in_ready,
  input  logic        flush,
  input  logic        fx2_flagc,
  output logic [15:0] fx2_fdata,
  output logic [1:0]  fx2_faddr,
  output logic        fx2_slwr,
  output logic        fx2_slrd,
  output logic        fx2_sloe,
  output logic        fx2_slcs,
  output logic        fx2_pkt_end
);

  localparam int unsigned CntW  = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT + 2);
  localparam int unsigned GapW  = $clog2(GAP_CYCLES + 2);

  localparam logic [CntW-1:0]  CntLast = CntW'(PKT_WORDS - 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(IDLE_TIMEOUT);
  localparam logic [GapW-1:0]  GapLast = GapW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StStream, StPktEnd, StGap} state_e;

  state_e           state_q, state_d;
  logic [15:0]      buf_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       occ_q;
  logic [CntW-1:0]  word_cnt_q, word_cnt_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             flush_pending_q, flush_pending_d;
  logic             accept, wr_en, commit, timeout;

  assign data_in_ready = !reset && (occ_q < 2'd2) && !flush_pending_q;
  assign accept        = data_in_valid && data_in_ready;
  assign wr_en         = (state_q == StStream) && (occ_q != 2'd0) && fx2_flagc;

  assign fx2_fdata   = buf_q[rd_ptr_q];
  assign fx2_slwr    = !wr_en;
  assign fx2_pkt_end = !commit;
  assign fx2_faddr   = 2'b10;
  assign fx2_slrd    = 1'b1;
  assign fx2_sloe    = 1'b1;
  assign fx2_slcs    = 1'b0;

  always_ff @(posedge fx2_ifclk or posedge reset) begin
    if (reset) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (accept) begin
        buf_q[wr_ptr_q] <= data_in;
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (wr_en) rd_ptr_q <= !rd_ptr_q;
      occ_q <= occ_q + 2'(accept) - 2'(wr_en);
    end
  end

  always_ff @(posedge fx2_ifclk or posedge reset) begin
    if (reset) begin
      state_q         <= StStream;
      word_cnt_q      <= '0;
      idle_q          <= '0;
      gap_q           <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      word_cnt_q      <= word_cnt_d;
      idle_q          <= idle_d;
      gap_q           <= gap_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    word_cnt_d      = word_cnt_q;
    idle_d          = idle_q;
    gap_d           = gap_q;
    flush_pending_d = flush_pending_q;
    commit          = 1'b0;
    timeout         = 1'b0;
    unique case (state_q)
      StStream: begin
        // Full packets wrap silently; the FX2 auto-commits them.
        if (wr_en) word_cnt_d = (word_cnt_q == CntLast) ? '0 : word_cnt_q + 1'b1;
        if (accept || wr_en) begin
          idle_d = '0;
        end else if (occ_q == 2'd0 && word_cnt_q != '0 && idle_q != IdleMax) begin
          idle_d = idle_q + 1'b1;
        end
        timeout = (IDLE_TIMEOUT != 0) && (idle_d == IdleMax) && (idle_q != IdleMax);
        if (flush_pending_q && occ_q == 2'd0) begin
          // Nothing written since the last commit: drop the request, no zero-length packet.
          if (word_cnt_q != '0) state_d = StPktEnd;
          else                  flush_pending_d = 1'b0;
        end else begin
          flush_pending_d = flush_pending_q || flush || timeout;
        end
      end
      StPktEnd: begin
        commit          = 1'b1;
        word_cnt_d      = '0;
        idle_d          = '0;
        gap_d           = '0;
        flush_pending_d = flush;
        state_d         = (GAP_CYCLES == 0) ? StStream : StGap;
      end
      StGap: begin
        idle_d          = '0;
        flush_pending_d = flush_pending_q || flush;
        if (gap_q == GapLast) state_d = StStream;
        else                  gap_d   = gap_q + 1'b1;
      end
      default: state_d = StStream;
    endcase
  end

endmodule
